// File: rtl/reg_serie_pkg.sv
// -----------------------------------------------------------------------------
// reg_serie_pkg
// Shared definitions for the left-shift serial register family.
//   state_t : transmitter FSM states (S_IDLE, S_SHIFT, S_PAR, S_GAP)
//   cnt_w   : counter width for a counter that must count n values
//             ($clog2(n) clamped to a minimum of 1 bit)
// -----------------------------------------------------------------------------
package reg_serie_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_PAR   = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  // A counter never narrower than one bit, even when only one value is needed.
  function automatic int cnt_w(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/reg_serializador_izq.sv
// -----------------------------------------------------------------------------
// reg_serializador_izq
// Parallel-in, serial-out left-shift transmitter. A WIDTH-bit word accepted on
// a valid/ready handshake is sent MSB first, one bit per clock, with `frame`
// marking the cycles that carry a bit. GAP idle cycles separate frames.
//
// Optional feature (compile-time macro REG_SERIALIZADOR_PARITY_EN):
//   defined   -> one even-parity bit follows the LSB (S_PAR state)
//   undefined -> frames carry WIDTH data bits only
//
// Parameters:
//   WIDTH     word width in bits (>= 2)
//   GAP       idle cycles forced between frames (0 allowed)
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   din       parallel word to send
//   din_valid din holds a word to send
//   din_ready transmitter can accept a word this cycle (high only in S_IDLE)
//   out       serial data, MSB first
//   frame     high while out carries a data or parity bit
//   done      registered one-cycle pulse after the last bit of a frame
// -----------------------------------------------------------------------------
module reg_serializador_izq
  import reg_serie_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             out,
  output logic             frame,
  output logic             done
);

  localparam int BW = cnt_w(WIDTH);
  localparam int GW = cnt_w(GAP + 1);

  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] BIT_ZERO = BW'(0);
  // Only compared against in S_GAP, which is unreachable when GAP == 0.
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);
  localparam logic [GW-1:0] GAP_ZERO = GW'(0);

  // Where the FSM goes once the last serial bit (data or parity) is done.
  localparam state_t AFTER_FRAME = (GAP > 0) ? S_GAP : S_IDLE;
`ifdef REG_SERIALIZADOR_PARITY_EN
  localparam state_t AFTER_BITS  = S_PAR;
`else
  localparam state_t AFTER_BITS  = AFTER_FRAME;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             done_q, done_d;
`ifdef REG_SERIALIZADOR_PARITY_EN
  logic             par_q, par_d;
`endif

  // Next-state logic: FSM, shift register, counters and done pulse.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    done_d    = 1'b0;
`ifdef REG_SERIALIZADOR_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        // din_ready is 1 throughout S_IDLE, so din_valid alone is the handshake.
        if (din_valid) begin
          shreg_d   = din;
          bit_cnt_d = BIT_ZERO;
`ifdef REG_SERIALIZADOR_PARITY_EN
          par_d     = ^din;
`endif
          state_d   = S_SHIFT;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_SHIFT: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = BIT_ZERO;
          gap_cnt_d = GAP_ZERO;
          state_d   = AFTER_BITS;
`ifdef REG_SERIALIZADOR_PARITY_EN
          done_d    = 1'b0;
`else
          done_d    = 1'b1;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_ONE;
        end
      end
      S_PAR: begin
`ifdef REG_SERIALIZADOR_PARITY_EN
        gap_cnt_d = GAP_ZERO;
        state_d   = AFTER_FRAME;
        done_d    = 1'b1;
`else
        state_d   = S_IDLE;
`endif
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = GAP_ZERO;
          state_d   = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset takes effect without a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shreg_q   <= {WIDTH{1'b0}};
      bit_cnt_q <= BIT_ZERO;
      gap_cnt_q <= GAP_ZERO;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      done_q    <= done_d;
    end
  end

`ifdef REG_SERIALIZADOR_PARITY_EN
  // Parity of the word captured at load, sent after the LSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  // Output decode from the registered state; out follows the shift MSB.
  always_comb begin
    din_ready = 1'b0;
    out       = 1'b0;
    frame     = 1'b0;
    case (state_q)
      S_IDLE: begin
        din_ready = 1'b1;
      end
      S_SHIFT: begin
        out   = shreg_q[WIDTH-1];
        frame = 1'b1;
      end
      S_PAR: begin
`ifdef REG_SERIALIZADOR_PARITY_EN
        out   = par_q;
        frame = 1'b1;
`else
        out   = 1'b0;
        frame = 1'b0;
`endif
      end
      S_GAP: begin
        din_ready = 1'b0;
      end
      default: begin
        din_ready = 1'b0;
      end
    endcase
  end

  assign done = done_q;

endmodule
